// File: rtl/merge_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : merge_write_arbiter_if
//  Brief    : Channel handshake and FIFO write-port bundle for the merge arbiter.
//  Revision : 1.0
// ============================================================================
interface merge_write_arbiter_if #(
    parameter int N_CH     = 4,
    parameter int TS_WIDTH = 28
);
    logic [N_CH-1:0]          Ch_valid;
    logic [N_CH*TS_WIDTH-1:0] Ch_data;
    logic [N_CH-1:0]          Ch_ready;
    logic                     Fifo_full;
    logic                     Fifo_almost_full;
    logic                     Fifo_wrerr;
    logic                     Fifo_rst;
    logic                     Fifo_wren;
    logic [31:0]              Fifo_din;

    // Arbiter side: consumes channel data, drives the FIFO write port.
    modport master (
        input  Ch_valid, Ch_data, Fifo_full, Fifo_almost_full, Fifo_wrerr,
        output Ch_ready, Fifo_rst, Fifo_wren, Fifo_din
    );

    // Environment side: TDC channels and the FIFO primitive.
    modport slave (
        output Ch_valid, Ch_data, Fifo_full, Fifo_almost_full, Fifo_wrerr,
        input  Ch_ready, Fifo_rst, Fifo_wren, Fifo_din
    );
endinterface
`default_nettype wire

// File: rtl/merge_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : merge_write_arbiter
//  Brief    : Round-robin merge of N_CH TDC channels into one FIFO write port,
//             with FIFO reset sequencing and a saturating write-error counter.
//  Revision : 1.0
// ============================================================================
module merge_write_arbiter #(
    parameter int N_CH        = 4,
    parameter int TS_WIDTH    = 28,
    parameter int RST_CYCLES  = 5,
    parameter int WAIT_CYCLES = 8
) (
    input  wire logic        Wclk,
    input  wire logic        Rst_n,
    input  wire logic        Flush,
    output logic             Ready,
    output logic [15:0]      Wrerr_count,
    merge_write_arbiter_if.master bus
);

    localparam int CNT_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(N_CH);
    localparam int TAG_W   = 32 - TS_WIDTH;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RST_WAIT = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_wren;
    logic [31:0]        r_din;
    logic [15:0]        r_wrerr_cnt;

    logic [TS_WIDTH-1:0] w_ts [N_CH];
    logic [N_CH-1:0]     w_grant;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [PTR_W-1:0]    w_scan_idx;
    logic [PTR_W:0]      w_scan_sum;
    logic                w_gnt_any;
    logic                w_grant_en;
    logic                w_flush_run;
    logic [TAG_W-1:0]    w_tag;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign w_ts[gi] = bus.Ch_data[gi*TS_WIDTH +: TS_WIDTH];
        end
    endgenerate

    assign w_grant_en  = !bus.Fifo_almost_full && !bus.Fifo_full;
    assign w_flush_run = Flush && (r_state == RUN);
    assign w_tag       = TAG_W'(w_gnt_idx);

    // ---------------- FSM ----------------
    always_ff @(posedge Wclk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= RST_HOLD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        bus.Fifo_rst = 1'b0;
        Ready        = 1'b0;
        case (r_state)
            RST_HOLD: begin
                bus.Fifo_rst = 1'b1;
                if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                    w_state_nxt = RST_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RST_WAIT: begin
                if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                Ready = 1'b1;
                if (Flush) begin
                    w_state_nxt = RST_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = RST_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Round-robin search: first valid channel at or after ptr, wrapping.
    always_comb begin
        w_grant    = '0;
        w_gnt_idx  = '0;
        w_gnt_any  = 1'b0;
        w_scan_sum = '0;
        w_scan_idx = '0;
        if ((r_state == RUN) && w_grant_en) begin
            for (int j = 0; j < N_CH; j++) begin
                w_scan_sum = {1'b0, r_ptr} + (PTR_W+1)'(j);
                if (w_scan_sum >= (PTR_W+1)'(N_CH))
                    w_scan_sum = w_scan_sum - (PTR_W+1)'(N_CH);
                w_scan_idx = w_scan_sum[PTR_W-1:0];
                if (!w_gnt_any && bus.Ch_valid[w_scan_idx]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_scan_idx;
                end
            end
        end
        if (w_gnt_any)
            w_grant[w_gnt_idx] = 1'b1;
    end

    assign bus.Ch_ready = w_grant;

    always_ff @(posedge Wclk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_ptr <= '0;
        end else if (w_gnt_any) begin
            r_ptr <= (w_gnt_idx == PTR_W'(N_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // A word handshaken on the flush edge is dropped; the FIFO is being wiped.
    always_ff @(posedge Wclk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wren <= 1'b0;
            r_din  <= '0;
        end else if (w_gnt_any && !Flush) begin
            r_wren <= 1'b1;
            r_din  <= {w_tag, w_ts[w_gnt_idx]};
        end else begin
            r_wren <= 1'b0;
        end
    end

    always_ff @(posedge Wclk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wrerr_cnt <= '0;
        end else if (w_flush_run) begin
            r_wrerr_cnt <= '0;
        end else if (bus.Fifo_wrerr && (r_wrerr_cnt != 16'hFFFF)) begin
            r_wrerr_cnt <= r_wrerr_cnt + 16'd1;
        end
    end

    assign bus.Fifo_wren = r_wren;
    assign bus.Fifo_din  = r_din;
    assign Wrerr_count   = r_wrerr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_merge_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_merge_write_arbiter
//  Brief    : Directed/randomised bench for merge_write_arbiter with a
//             cycle-level behavioural model of startup, arbitration and writes.
//  Revision : 1.0
// ============================================================================
module tb_merge_write_arbiter;

    localparam int N   = 4;
    localparam int TSW = 28;
    localparam int RC  = 5;
    localparam int WC  = 8;
    localparam int SU  = RC + WC;

    logic        Wclk  = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Flush = 1'b0;
    logic        Ready;
    logic [15:0] Wrerr_count;

    merge_write_arbiter_if #(.N_CH(N), .TS_WIDTH(TSW)) bus();

    merge_write_arbiter #(
        .N_CH(N), .TS_WIDTH(TSW), .RST_CYCLES(RC), .WAIT_CYCLES(WC)
    ) dut (
        .Wclk        (Wclk),
        .Rst_n       (Rst_n),
        .Flush       (Flush),
        .Ready       (Ready),
        .Wrerr_count (Wrerr_count),
        .bus         (bus)
    );

    always #5 Wclk = ~Wclk;

    int total = 0;
    int bad   = 0;

    // channel sources
    bit              src_valid [N];
    logic [TSW-1:0]  src_data  [N];
    bit [N-1:0]      en_mask   = '1;
    bit              always_on = 1'b1;
    bit              fix1      = 1'b0;
    int              vprob     = 50;

    // reference model
    int          m_cyc;
    int          m_ptr;
    int          m_cnt;
    bit          m_wren;
    logic [31:0] m_din;
    int          grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (m_cyc < SU || bus.Fifo_almost_full || bus.Fifo_full) return -1;
        for (int j = 0; j < N; j++) begin
            int c;
            c = (m_ptr + j) % N;
            if (src_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_sources();
        for (int c = 0; c < N; c++) begin
            if (!en_mask[c]) begin
                src_valid[c] = 1'b0;
            end else if (!src_valid[c]) begin
                src_valid[c] = always_on || ($urandom_range(99) < vprob);
                src_data[c]  = (fix1 && c == 1) ? 28'h0ABCDEF : TSW'($urandom);
            end
            bus.Ch_valid[c]           = src_valid[c];
            bus.Ch_data[c*TSW +: TSW] = src_data[c];
        end
    endtask

    task automatic check_outs(input int g);
        logic [31:0] exp_rdy;
        exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
        chk("fifo_rst",    32'(bus.Fifo_rst),  32'(m_cyc < RC));
        chk("ready",       32'(Ready),         32'(m_cyc >= SU));
        chk("ch_ready",    32'(bus.Ch_ready),  exp_rdy);
        chk("fifo_wren",   32'(bus.Fifo_wren), 32'(m_wren));
        chk("fifo_din",    bus.Fifo_din,       m_din);
        chk("wrerr_count", 32'(Wrerr_count),   32'(m_cnt));
    endtask

    // One clock cycle: drive, check, advance model, cross the edge.
    task automatic tick();
        int g;
        drive_sources();
        #1;
        g = model_grant();
        check_outs(g);
        if (m_cyc >= SU && Flush) begin
            m_cyc  = 0;
            m_cnt  = 0;
            m_wren = 1'b0;
        end else begin
            m_wren = (g >= 0);
            if (g >= 0) m_din = {4'(g), src_data[g]};
            if (bus.Fifo_wrerr && m_cnt < 65535) m_cnt++;
            if (m_cyc < SU) m_cyc++;
        end
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            src_valid[g] = 1'b0;
            grants.push_back(g);
        end
        @(posedge Wclk);
        #1;
    endtask

    task automatic do_reset();
        Rst_n  = 1'b0;
        m_cyc  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        m_wren = 1'b0;
        m_din  = '0;
        drive_sources();
        #1;
        check_outs(-1);
        @(posedge Wclk);
        #1;
        check_outs(-1);
        Rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bus.Fifo_full        = 1'b0;
        bus.Fifo_almost_full = 1'b0;
        bus.Fifo_wrerr       = 1'b0;
        bus.Ch_valid         = '0;
        bus.Ch_data          = '0;
        for (int c = 0; c < N; c++) begin
            src_valid[c] = 1'b0;
            src_data[c]  = '0;
        end

        // Power-up reset and startup sequence, all channels requesting
        #2;
        do_reset();
        repeat (SU) tick();
        chk("ready_after_startup", 32'(Ready), 32'd1);

        // All channels valid: strict rotation, one word per cycle
        grants.delete();
        repeat (12) tick();
        for (int i = 0; i < 8; i++)
            chk("rotation", 32'(grants[i]), 32'((grants[0] + i) % N));

        // Channels 1 and 3 only, starting from ptr=2
        n = 0;
        while (m_ptr != 2 && n < 8) begin
            tick();
            n++;
        end
        chk("ptr_reached_2", 32'(m_ptr), 32'd2);
        en_mask = 4'b1010;
        fix1    = 1'b1;
        grants.delete();
        tick();
        tick();
        chk("din_ch1", bus.Fifo_din, 32'h10ABCDEF);
        tick();
        tick();
        chk("order0", 32'(grants[0]), 32'd3);
        chk("order1", 32'(grants[1]), 32'd1);
        chk("order2", 32'(grants[2]), 32'd3);
        chk("order3", 32'(grants[3]), 32'd1);

        // Almost-full back-pressure for 10 cycles during traffic
        en_mask = '1;
        fix1    = 1'b0;
        tick();
        bus.Fifo_almost_full = 1'b1;
        repeat (10) tick();
        bus.Fifo_almost_full = 1'b0;
        repeat (6) tick();

        // Three write errors, then flush from RUN
        always_on = 1'b0;
        repeat (3) begin
            bus.Fifo_wrerr = 1'b1;
            tick();
            bus.Fifo_wrerr = 1'b0;
            tick();
        end
        chk("wrerr_before_flush", 32'(Wrerr_count), 32'd3);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("wrerr_after_flush", 32'(Wrerr_count), 32'd0);
        chk("ready_after_flush", 32'(Ready), 32'd0);
        tick();
        Flush = 1'b1;   // ignored while the reset sequence runs
        tick();
        Flush = 1'b0;
        repeat (SU) tick();

        // Randomised traffic with back-pressure, errors and rare flushes
        for (int i = 0; i < 80; i++) begin
            bus.Fifo_almost_full = ($urandom_range(7) == 0);
            bus.Fifo_full        = ($urandom_range(15) == 0);
            bus.Fifo_wrerr       = ($urandom_range(9) == 0);
            Flush                = ($urandom_range(39) == 0);
            tick();
        end
        bus.Fifo_almost_full = 1'b0;
        bus.Fifo_full        = 1'b0;
        bus.Fifo_wrerr       = 1'b0;
        Flush                = 1'b0;
        repeat (SU) tick();

        // Asynchronous reset mid-traffic, then normal startup again
        always_on = 1'b1;
        repeat (3) tick();
        #2;
        do_reset();
        repeat (SU + 8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/merge_write_arbiter.md
# merge_write_arbiter

Write-side controller for the merging-stage FIFO (FIFO36E1, 36-bit mode, asynchronous, write clock = Wclk). Shares the single FIFO write port among N_CH TDC channel outputs with round-robin arbitration and tags each timestamp with its channel number. Runs the FIFO reset sequence after power-up and on a flush request, and counts write errors. Sits between the per-channel TDC encoders and `memory_ctrl`; the read side is out of scope.

## Interface
- N_CH, 4, number of TDC channels (2..16)
- TS_WIDTH, 28, timestamp width per channel; channel tag is 32-TS_WIDTH = 4 bits
- RST_CYCLES, 5, Wclk cycles Fifo_rst is held high (≥5)
- WAIT_CYCLES, 8, Wclk cycles after Fifo_rst falls before the first write

Ports:
- Wclk  in  1  clock; same clock as the FIFO write port
- Rst_n  in  1  reset, asynchronous, active-low
- Flush  in  1  synchronous single-cycle pulse; re-runs the FIFO reset sequence
- Ch_valid  in  N_CH  per-channel timestamp valid
- Ch_data  in  N_CH*TS_WIDTH  channel i timestamp at bits [i*TS_WIDTH +: TS_WIDTH]
- Ch_ready  out  N_CH  one-hot grant; transfer when Ch_valid[i] & Ch_ready[i]
- Fifo_full  in  1  FIFO FULL
- Fifo_almost_full  in  1  FIFO ALMOSTFULL
- Fifo_wrerr  in  1  FIFO WRERR
- Fifo_rst  out  1  FIFO RST
- Fifo_wren  out  1  FIFO WREN, registered
- Fifo_din  out  32  FIFO DI, registered, {channel[3:0], timestamp}
- Ready  out  1  high in RUN
- Wrerr_count  out  16  saturating count of Fifo_wrerr cycles

## Operation
- FSM states: RST_HOLD, RST_WAIT, RUN.
- RST_HOLD: Fifo_rst=1, Ch_ready=0, Fifo_wren=0. Counts RST_CYCLES cycles, then moves to RST_WAIT.
- RST_WAIT: Fifo_rst=0, Ch_ready=0, Fifo_wren=0. Counts WAIT_CYCLES cycles, then moves to RUN.
- RUN: Ready=1, arbitration enabled.
  - Flush=1 moves to RST_HOLD on the next edge.
  - Flush in RST_HOLD/RST_WAIT is ignored; it does not restart the counter.
- Arbitration (RUN only):
  - Grant enable = !Fifo_almost_full & !Fifo_full.
  - Ch_ready is combinational from the state, pointer, Ch_valid and grant enable.
  - At most one bit is set: the first i with Ch_valid[i]=1, searching from ptr upward and wrapping modulo N_CH.
  - Ch_ready is 0 when no channel is valid or the grant is disabled.
- Pointer:
  - ptr resets to 0.
  - After a grant to channel g, ptr ← (g+1) mod N_CH.
  - ptr is unchanged when there is no grant.
- A channel that is not granted keeps Ch_valid and Ch_data stable; the block never drops data.
- Write path: on a grant to channel g, the next edge sets Fifo_wren=1 and Fifo_din = {g[3:0], Ch_data[g]}. With no grant, Fifo_wren=0 and Fifo_din holds its last value.
- Wrerr_count:
  - Increments each cycle Fifo_wrerr=1; saturates at 16'hFFFF.
  - Cleared on Flush entry into RST_HOLD and by reset.
- Channel tag is 4 bits wide whatever N_CH is; unused tag values never occur.

## Timing
- Reset values (Rst_n=0, asynchronous):
  - State=RST_HOLD with the counter cleared.
  - Fifo_rst=1, Fifo_wren=0, Fifo_din=0, Ch_ready=0, Ready=0, Wrerr_count=0, ptr=0.
- Startup after Rst_n rises: Fifo_rst stays high for RST_CYCLES edges, then low. The first possible Ch_ready is WAIT_CYCLES edges later. Default is 13 edges after release.
- Latency: handshake at edge k → Fifo_wren=1 with the data during cycle k+1 (one cycle).
- Throughput: one word per cycle while enabled; N valid channels each get one grant in every N consecutive grants.
- Almost-full: Fifo_almost_full sampled high forces Ch_ready=0 in the same cycle. A write already registered still completes. The 128-word offset absorbs that single in-flight word.
- Flush in RUN:
  - A write already registered at the flush edge is suppressed (Fifo_wren=0 in RST_HOLD).
  - That word is lost by design; the flush discards the FIFO contents anyway.
- Rst_n asserted mid-RUN: all outputs take reset values immediately. Any in-progress write is dropped.
- Fifo_wren is never high in the same cycle as Fifo_rst, nor during RST_WAIT.

## Test plan
- Reset release, defaults: Fifo_rst high for exactly 5 cycles. Ready and first Ch_ready 8 cycles after Fifo_rst falls. No Fifo_wren before that.
- All 4 channels valid continuously in RUN → grants 0,1,2,3,0,… one per cycle. Fifo_din tags 0,1,2,3 in order. Each word appears on Fifo_din one cycle after its handshake, with the matching timestamp.
- Only channels 1 and 3 valid, ptr=2 → grant order 3,1,3,1. Channel 1 holds Ch_data=28'h0ABCDEF until granted, then Fifo_din=32'h10ABCDEF.
- Fifo_almost_full driven high for 10 cycles during traffic → Ch_ready=0 for those 10 cycles. At most one Fifo_wren after it rises. Grants resume the first cycle it is low, with no word lost or duplicated.
- Flush pulse in RUN with 3 Fifo_wrerr pulses already counted (Wrerr_count=3) → Wrerr_count=0 next cycle, Ready=0, Fifo_rst high 5 cycles, Ready again after 8 more.
- Rst_n pulsed low for 1 cycle mid-traffic → every output at its reset value immediately, then the normal 13-cycle startup sequence.
